// File: rtl/deck_pkg.sv
// Card encoding, canonical UNO deck order and shared FSM / LFSR constants
// for the deck dealer.
package deck_pkg;

   localparam int CARD_W = 6;
   localparam int CARDS_PER_COLOR = 27;
   localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2,
      BLUE   = 2'd3
   } color_t;

   localparam logic [3:0] VAL_SKIP    = 4'd10;
   localparam logic [3:0] VAL_REVERSE = 4'd11;
   localparam logic [3:0] VAL_DRAW2   = 4'd12;
   localparam logic [3:0] VAL_WILD    = 4'd13;
   localparam logic [3:0] VAL_WILD4   = 4'd14;

   typedef enum logic {
      S_READY   = 1'b0,
      S_SHUFFLE = 1'b1
   } state_t;

   // Block layout per color: 0, 1,1, 2,2 .. 9,9, SKIP x2, REVERSE x2, DRAW2 x2, WILD, WILD4.
   function automatic logic [CARD_W-1:0] canonical_card(input int idx);
      color_t     color;
      int         off;
      logic [3:0] value;
      color = color_t'(2'((idx / CARDS_PER_COLOR) % 4));
      off   = idx % CARDS_PER_COLOR;
      if (off == 0)
         value = 4'd0;
      else if (off <= 18)
         value = 4'((off + 1) / 2);
      else if (off <= 20)
         value = VAL_SKIP;
      else if (off <= 22)
         value = VAL_REVERSE;
      else if (off <= 24)
         value = VAL_DRAW2;
      else if (off == 25)
         value = VAL_WILD;
      else
         value = VAL_WILD4;
      return {color, value};
   endfunction

endpackage

// File: rtl/deck_lfsr.sv
// Galois LFSR used as the shuffle random source; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module deck_lfsr
   import deck_pkg::*;
#(
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEFAULT)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_step,
   output logic [LFSR_W-1:0] o_value
);

   logic [LFSR_W-1:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (i_load)
         value_d = (i_seed == '0) ? LFSR_W'(1) : i_seed;
      else if (i_step)
         value_d = value_q[0] ? ((value_q >> 1) ^ LFSR_TAPS) : (value_q >> 1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         value_q <= LFSR_W'(1);
      else
         value_q <= value_d;
   end

   assign o_value = value_q;

endmodule

// File: rtl/deck_dealer.sv
// Deck store with Fisher-Yates shuffle (full reload or undrawn remainder only)
// and a one-card-per-request draw port; all outputs registered.
module deck_dealer
   import deck_pkg::*;
#(
   parameter int                N_CARDS   = 108,
   parameter int                CARD_W    = deck_pkg::CARD_W,
   parameter int                IDX_W     = $clog2(N_CARDS),
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(LFSR_TAPS_DEFAULT)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_draw,
   output logic [CARD_W-1:0] o_card,
   output logic              o_card_valid,
   output logic              o_draw_err,
   output logic              o_busy,
   output logic [IDX_W:0]    o_remaining,
   output logic              o_empty
);

   typedef logic [CARD_W-1:0] card_t;
   typedef logic [IDX_W:0]    cnt_t;
   typedef logic [IDX_W-1:0]  idx_t;

   localparam cnt_t N_CNT    = cnt_t'(N_CARDS);
   localparam idx_t LAST_IDX = idx_t'(N_CARDS - 1);

   state_t state_q, state_d;
   card_t  deck_q [N_CARDS];
   card_t  deck_d [N_CARDS];
   cnt_t   top_q, top_d;
   idx_t   end_q, end_d;
   card_t  card_q, card_d;
   logic   card_vld_q, card_vld_d;
   logic   draw_err_q, draw_err_d;
   logic   busy_q, busy_d;
   logic   empty_q, empty_d;
   cnt_t   remaining_q, remaining_d;

   logic              lfsr_load, lfsr_step;
   logic [LFSR_W-1:0] lfsr_val;
   logic              lfsr_unused;
   idx_t              r;
   logic              r_in_range;

   deck_lfsr #(
      .LFSR_W    (LFSR_W),
      .LFSR_TAPS (LFSR_TAPS)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (lfsr_load),
      .i_seed  (i_seed),
      .i_step  (lfsr_step),
      .o_value (lfsr_val)
   );

   // Candidate slot comes from the pre-advance LFSR value; only low bits are used.
   assign r           = lfsr_val[IDX_W-1:0];
   assign lfsr_unused = ^(lfsr_val >> IDX_W);
   assign r_in_range  = ({1'b0, r} >= top_q) && (r <= end_q);

   always_comb begin
      state_d    = state_q;
      top_d      = top_q;
      end_d      = end_q;
      deck_d     = deck_q;
      card_d     = card_q;
      card_vld_d = 1'b0;
      draw_err_d = 1'b0;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;

      case (state_q)
         S_READY: begin
            if (i_start) begin
               lfsr_load  = 1'b1;
               end_d      = LAST_IDX;
               draw_err_d = i_draw;   // start wins over a same-cycle draw
               if (!i_mode) begin
                  top_d = '0;
                  for (int i = 0; i < N_CARDS; i++)
                     deck_d[i] = card_t'(canonical_card(i));
               end
               state_d = S_SHUFFLE;
            end else if (i_draw) begin
               if (top_q < N_CNT) begin
                  card_d     = deck_q[top_q[IDX_W-1:0]];
                  top_d      = top_q + 1'b1;
                  card_vld_d = 1'b1;
               end else begin
                  draw_err_d = 1'b1;
               end
            end
         end
         S_SHUFFLE: begin
            lfsr_step  = 1'b1;
            draw_err_d = i_draw;
            if ({1'b0, end_q} <= top_q) begin
               state_d = S_READY;
            end else if (r_in_range) begin
               deck_d[r]     = deck_q[end_q];
               deck_d[end_q] = deck_q[r];
               end_d         = end_q - 1'b1;
               if ({1'b0, end_q} == top_q + 1'b1)
                  state_d = S_READY;
            end
         end
         default: state_d = S_READY;
      endcase

      remaining_d = N_CNT - top_d;
      empty_d     = (top_d == N_CNT);
      busy_d      = (state_d == S_SHUFFLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_READY;
         top_q   <= '0;
         end_q   <= LAST_IDX;
         for (int i = 0; i < N_CARDS; i++)
            deck_q[i] <= card_t'(canonical_card(i));
         card_q      <= '0;
         card_vld_q  <= 1'b0;
         draw_err_q  <= 1'b0;
         busy_q      <= 1'b0;
         empty_q     <= 1'b0;
         remaining_q <= N_CNT;
      end else begin
         state_q     <= state_d;
         top_q       <= top_d;
         end_q       <= end_d;
         deck_q      <= deck_d;
         card_q      <= card_d;
         card_vld_q  <= card_vld_d;
         draw_err_q  <= draw_err_d;
         busy_q      <= busy_d;
         empty_q     <= empty_d;
         remaining_q <= remaining_d;
      end
   end

   assign o_card       = card_q;
   assign o_card_valid = card_vld_q;
   assign o_draw_err   = draw_err_q;
   assign o_busy       = busy_q;
   assign o_remaining  = remaining_q;
   assign o_empty      = empty_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Bench for deck_dealer: directed vector table plus hand-written shuffle,
// drain, partial-reshuffle and reset-during-shuffle sequences against a reference model.
module tb_deck_dealer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic        i_mode;
   logic [15:0] i_seed;
   logic        i_draw;
   logic [5:0]  o_card;
   logic        o_card_valid;
   logic        o_draw_err;
   logic        o_busy;
   logic [7:0]  o_remaining;
   logic        o_empty;

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   deck_dealer dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_mode       (i_mode),
      .i_seed       (i_seed),
      .i_draw       (i_draw),
      .o_card       (o_card),
      .o_card_valid (o_card_valid),
      .o_draw_err   (o_draw_err),
      .o_busy       (o_busy),
      .o_remaining  (o_remaining),
      .o_empty      (o_empty)
   );

   typedef struct {
      logic        draw;
      logic        start;
      logic        mode;
      logic [15:0] seed;
      logic [5:0]  card;
      logic        vld;
      logic        err;
      logic        busy;
      logic [7:0]  rem;
   } vec_t;

   vec_t       vecs [8];
   logic [5:0] canon [108];
   logic [5:0] m_deck [108];
   logic [5:0] got [108];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // Reference shuffle: cyc is the number of cycles the dealer should spend busy.
   task automatic model_shuffle(input logic [15:0] seed, input bit mode, input int top, output int cyc);
      logic [15:0] lf;
      logic [5:0]  t;
      int          e;
      int          r;
      lf  = (seed == 16'h0) ? 16'h1 : seed;
      e   = 107;
      cyc = 0;
      if (!mode) m_deck = canon;
      while (cyc < 20000) begin
         cyc++;
         r  = int'(lf[6:0]);
         lf = lfsr_next(lf);
         if (e <= top) break;
         if (r >= top && r <= e) begin
            t         = m_deck[r];
            m_deck[r] = m_deck[e];
            m_deck[e] = t;
            if (e == top + 1) break;
            e--;
         end
      end
   endtask

   task automatic start_shuffle(input bit mode, input logic [15:0] seed);
      i_start = 1'b1;
      i_mode  = mode;
      i_seed  = seed;
      cycle();
      i_start = 1'b0;
   endtask

   task automatic draw_one();
      i_draw = 1'b1;
      cycle();
      i_draw = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int base, input int exp_cyc);
      int n;
      n = base;
      while (o_busy && n < 5000) begin
         n++;
         cycle();
      end
      if (n >= 5000) chk({name, "_timeout"}, 32'd1, 32'd0);
      chk({name, "_busy_cycles"}, n, exp_cyc);
   endtask

   task automatic draw_check(input string name, input int first, input int count, input bit use_model);
      logic [5:0] exp;
      for (int k = first; k < first + count; k++) begin
         draw_one();
         exp    = use_model ? m_deck[k] : canon[k];
         got[k] = o_card;
         chk($sformatf("%s_card%0d", name, k), {o_card_valid, o_card}, {1'b1, exp});
      end
   endtask

   task automatic hist_check(input string name, input int lo, input int hi);
      int h [64];
      int bad;
      for (int i = 0; i < 64; i++) h[i] = 0;
      for (int i = lo; i <= hi; i++) begin
         h[got[i]]++;
         h[canon[i]]--;
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (h[i] != 0) bad++;
      chk(name, bad, 0);
   endtask

   initial begin
      int cyc;
      int n;
      int wilds;
      int diffs;

      n = 0;
      for (int c = 0; c < 4; c++) begin
         canon[n] = 6'(c * 16); n++;
         for (int v = 1; v <= 12; v++) begin
            canon[n] = 6'(c * 16 + v); n++;
            canon[n] = 6'(c * 16 + v); n++;
         end
         canon[n] = 6'(c * 16 + 13); n++;
         canon[n] = 6'(c * 16 + 14); n++;
      end

      //           draw  start mode  seed      card   vld   err   busy  rem
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 6'h00, 1'b1, 1'b0, 1'b0, 8'd107};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 6'h01, 1'b1, 1'b0, 1'b0, 8'd106};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 6'h01, 1'b1, 1'b0, 1'b0, 8'd105};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 6'h01, 1'b0, 1'b0, 1'b0, 8'd105};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 6'h02, 1'b1, 1'b0, 1'b0, 8'd104};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h1234, 6'h02, 1'b0, 1'b1, 1'b1, 8'd104};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 6'h02, 1'b0, 1'b1, 1'b1, 8'd104};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h5555, 6'h02, 1'b0, 1'b0, 1'b1, 8'd104};

      i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_seed = 16'h0; i_draw = 1'b0;
      cycle();
      cycle();
      chk("rst_card", o_card, 6'h00);
      chk("rst_vld", o_card_valid, 1'b0);
      chk("rst_err", o_draw_err, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_rem", o_remaining, 8'd108);
      chk("rst_empty", o_empty, 1'b0);
      i_rst = 1'b0;
      cycle();

      for (int i = 0; i < 8; i++) begin
         i_draw  = vecs[i].draw;
         i_start = vecs[i].start;
         i_mode  = vecs[i].mode;
         i_seed  = vecs[i].seed;
         cycle();
         i_draw  = 1'b0;
         i_start = 1'b0;
         chk($sformatf("vec%0d_card", i), o_card, vecs[i].card);
         chk($sformatf("vec%0d_vld", i), o_card_valid, vecs[i].vld);
         chk($sformatf("vec%0d_err", i), o_draw_err, vecs[i].err);
         chk($sformatf("vec%0d_busy", i), o_busy, vecs[i].busy);
         chk($sformatf("vec%0d_rem", i), o_remaining, vecs[i].rem);
         chk($sformatf("vec%0d_empty", i), o_empty, 1'b0);
      end

      // Mode-1 shuffle of slots 4..107 that was started inside the table.
      m_deck = canon;
      model_shuffle(16'h1234, 1'b1, 4, cyc);
      wait_idle("m1_top4", 2, cyc);
      chk("m1_top4_rem", o_remaining, 8'd104);
      draw_check("m1_top4", 4, 104, 1'b1);
      chk("drain_empty", o_empty, 1'b1);
      chk("drain_rem", o_remaining, 8'd0);
      draw_one();
      chk("empty_draw_err", o_draw_err, 1'b1);
      chk("empty_draw_vld", o_card_valid, 1'b0);
      chk("empty_draw_card_hold", o_card, m_deck[107]);
      cycle();
      chk("err_one_cycle", o_draw_err, 1'b0);

      // Mode-1 start with nothing left to shuffle finishes on entry.
      model_shuffle(16'h0007, 1'b1, 108, cyc);
      start_shuffle(1'b1, 16'h0007);
      wait_idle("m1_empty", 0, cyc);
      chk("m1_empty_rem", o_remaining, 8'd0);

      // Full mode-0 shuffle, twice with the same seed.
      for (int pass = 0; pass < 2; pass++) begin
         model_shuffle(16'hACE1, 1'b0, 0, cyc);
         start_shuffle(1'b0, 16'hACE1);
         chk($sformatf("m0_p%0d_remaining", pass), o_remaining, 8'd108);
         wait_idle($sformatf("m0_p%0d", pass), 0, cyc);
         draw_check($sformatf("m0_p%0d", pass), 0, 108, 1'b1);
      end
      chk("m0_busy_min", cyc >= 107, 1'b1);
      hist_check("m0_hist", 0, 107);
      wilds = 0;
      diffs = 0;
      for (int i = 0; i < 108; i++) begin
         if (got[i][3:0] == 4'hD) wilds++;
         if (got[i] != canon[i]) diffs++;
      end
      chk("m0_wild_count", wilds, 4);
      chk("m0_order_differs", diffs != 0, 1'b1);

      // Partial reshuffle of the last 8 slots after 100 canonical draws.
      i_rst = 1'b1;
      cycle();
      i_rst = 1'b0;
      draw_check("pre_m1", 0, 100, 1'b0);
      chk("pre_m1_rem", o_remaining, 8'd8);
      m_deck = canon;
      model_shuffle(16'hBEEF, 1'b1, 100, cyc);
      start_shuffle(1'b1, 16'hBEEF);
      wait_idle("m1_top100", 0, cyc);
      chk("m1_top100_rem", o_remaining, 8'd8);
      draw_check("m1_top100", 100, 8, 1'b1);
      hist_check("m1_top100_hist", 100, 107);

      // Asynchronous reset at shuffle cycle 50.
      start_shuffle(1'b0, 16'hACE1);
      repeat (49) cycle();
      chk("mid_busy_before_rst", o_busy, 1'b1);
      i_rst = 1'b1;
      #1;
      chk("arst_busy", o_busy, 1'b0);
      chk("arst_rem", o_remaining, 8'd108);
      chk("arst_vld", o_card_valid, 1'b0);
      chk("arst_card", o_card, 6'h00);
      chk("arst_empty", o_empty, 1'b0);
      cycle();
      i_rst = 1'b0;
      draw_check("post_rst", 0, 108, 1'b0);
      chk("last_card", o_card, 6'h3E);
      chk("full_drain_empty", o_empty, 1'b1);
      draw_one();
      chk("overdraw_err", o_draw_err, 1'b1);
      chk("overdraw_vld", o_card_valid, 1'b0);
      chk("overdraw_card", o_card, 6'h3E);
      chk("overdraw_empty", o_empty, 1'b1);

      // A zero seed behaves as seed 1.
      model_shuffle(16'h0000, 1'b0, 0, cyc);
      start_shuffle(1'b0, 16'h0000);
      wait_idle("seed0", 0, cyc);
      draw_check("seed0", 0, 6, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
